// File: rtl/bcd_pkg.sv
// Shared constants, FSM state type and power-of-ten helper
// for the sequential binary-to-BCD converter.
package bcd_pkg;

  localparam int         DIGIT_W     = 4;
  localparam logic [3:0] ADD3_THRESH = 4'd5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  function automatic logic [63:0] pow10(input int n);
    logic [63:0] r;
    r = 64'd1;
    for (int i = 0; i < n; i++) begin
      r = r * 64'd10;
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble correction cell: digits >= 5 get +3 before the shift.
// Ports: i_digit (4b BCD digit in), o_digit (4b corrected digit out).
module bcd_add3
  import bcd_pkg::*;
(
  input  logic [3:0] i_digit,
  output logic [3:0] o_digit
);

  assign o_digit = (i_digit >= ADD3_THRESH) ? i_digit + 4'd3 : i_digit;

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Iterative binary-to-BCD converter, one add-3/shift step per clock.
// Ports: clk, rst_n, start/bin_in in; ready, done, bcd_out, overflow, blank out.
module bin_to_bcd_seq
  import bcd_pkg::*;
#(
  parameter int BIN_W  = 14,
  parameter int DIGITS = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [BIN_W-1:0]        bin_in,
  output logic                    ready,
  output logic                    done,
  output logic [4*DIGITS-1:0]     bcd_out,
  output logic                    overflow,
  output logic [DIGITS-1:0]       blank
);

  // one extra guard digit so the add/shift never drops a carry
  localparam int DF_W  = (DIGITS + 1) * DIGIT_W;
  localparam int SR_W  = DF_W + BIN_W;
  localparam int OUT_W = DIGITS * DIGIT_W;
  localparam int CNT_W = $clog2(BIN_W);

  localparam logic [63:0] MAXV    = pow10(DIGITS) - 64'd1;
  localparam logic [63:0] BIN_MAX =
    (BIN_W >= 64) ? {64{1'b1}} : ((64'd1 << BIN_W) - 64'd1);
  localparam bit          HAS_OVF = (BIN_MAX > MAXV);

  localparam logic [CNT_W-1:0]  LAST      = CNT_W'(BIN_W - 1);
  localparam logic [OUT_W-1:0]  SAT       = {DIGITS{4'h9}};
  localparam logic [DIGITS-1:0] BLANK_RST =
    {DIGITS{1'b1}} ^ DIGITS'(1);

  state_e             r_state;
  logic [SR_W-1:0]    r_sr;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_ovf;
  logic [OUT_W-1:0]   r_bcd;
  logic               r_overflow;
  logic [DIGITS-1:0]  r_blank;

  logic [DF_W-1:0]    w_df_adj;
  logic [SR_W-1:0]    w_sr_adj;
  logic [SR_W-1:0]    w_sr_nxt;
  logic [OUT_W-1:0]   w_digits;
  logic [OUT_W-1:0]   w_res;
  logic               w_ovf_in;
  logic [DIGITS-1:0]  w_blank;
  logic               w_allz;

  genvar g;
  generate
    for (g = 0; g <= DIGITS; g++) begin : g_add3
      bcd_add3 u_add3 (
        .i_digit (r_sr[BIN_W + DIGIT_W*g +: DIGIT_W]),
        .o_digit (w_df_adj[DIGIT_W*g +: DIGIT_W])
      );
    end
  endgenerate

  assign w_sr_adj = {w_df_adj, r_sr[BIN_W-1:0]};
  assign w_sr_nxt = w_sr_adj << 1;
  assign w_digits = w_sr_nxt[BIN_W +: OUT_W];
  assign w_res    = r_ovf ? SAT : w_digits;

  generate
    if (HAS_OVF) begin : g_ovf
      assign w_ovf_in = (64'(bin_in) > MAXV);
    end else begin : g_no_ovf
      assign w_ovf_in = 1'b0;
    end
  endgenerate

  // scan from the top digit down; a digit blanks while all above are zero
  always_comb begin
    w_blank = '0;
    w_allz  = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      w_allz     = w_allz & (w_res[DIGIT_W*i +: DIGIT_W] == 4'd0);
      w_blank[i] = w_allz;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_sr       <= '0;
      r_cnt      <= '0;
      r_ovf      <= 1'b0;
      r_bcd      <= '0;
      r_overflow <= 1'b0;
      r_blank    <= BLANK_RST;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (start) begin
            r_sr    <= {{DF_W{1'b0}}, bin_in};
            r_ovf   <= w_ovf_in;
            r_cnt   <= '0;
            r_state <= SHIFT;
          end
        end
        SHIFT: begin
          r_sr  <= w_sr_nxt;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == LAST) begin
            r_state    <= DONE;
            r_bcd      <= w_res;
            r_overflow <= r_ovf;
            r_blank    <= w_blank;
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign ready    = (r_state == IDLE);
  assign done     = (r_state == DONE);
  assign bcd_out  = r_bcd;
  assign overflow = r_overflow;
  assign blank    = r_blank;

endmodule
